// File: rtl/display_scan.sv
// Four-digit seven-segment scan controller: frame snapshot, digit select,
// blanked anode drive and leading-zero suppression.

// One digit of the suppression chain plus its anode enable.
module display_scan_lane #(
  parameter bit CAN_SUP = 1'b1
) (
  input  logic [3:0] num_i,
  input  logic       pt_i,
  input  logic       sup_hi_i,
  input  logic       on_i,
  output logic       sup_o,
  output logic       an_o
);
  // A digit is blank-able only while every more-significant digit is blank.
  assign sup_o = CAN_SUP & sup_hi_i & (num_i == 4'd0) & ~pt_i;
  assign an_o  = ~(on_i & ~sup_o);
endmodule

module display_scan #(
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       lz_en,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] dp_in,
  output logic [3:0] num0,
  output logic [3:0] num1,
  output logic [3:0] num2,
  output logic [3:0] num3,
  output logic [3:0] point,
  output logic       Sel1,
  output logic       Sel2,
  output logic [3:0] AN,
  output logic       frame_tick
);
  localparam int ND = 4;
  localparam int CW = $clog2(PRESCALE);

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

  typedef struct packed {
    logic [ND-1:0][3:0] num;
    logic [ND-1:0]      pt;
    logic               lz;
  } snap_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  snap_t         snap_q, snap_d;
  logic          snap_take;
  logic [ND-1:0] an_q, an_d;
  logic          tick_q;
  logic [ND:0]   sup_chain;
  logic [ND-1:0] on_sel;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    idx_d     = idx_q;
    snap_take = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (en) begin
          state_d   = BLANK;
          snap_take = 1'b1;
        end
      end
      BLANK: if (cnt_q == CW'(BLANK_CYC - 1)) state_d = ON;
      ON: if (cnt_q == CW'(PRESCALE - 1)) begin
        state_d   = BLANK;
        cnt_d     = '0;
        idx_d     = idx_q + 2'd1;
        snap_take = (idx_q == 2'd3);
      end
      default: state_d = IDLE;
    endcase
    // Dropping en parks the scan regardless of where the slot is.
    if (!en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      idx_d     = '0;
      snap_take = 1'b0;
    end
  end

  always_comb begin
    snap_d = snap_q;
    if (snap_take) begin
      snap_d.num = {d3, d2, d1, d0};
      snap_d.pt  = dp_in;
      snap_d.lz  = lz_en;
    end
  end

  // Suppression runs off the latched frame, so it is fixed for the frame.
  assign sup_chain[ND] = snap_q.lz;

  for (genvar g = 0; g < ND; g++) begin : g_lane
    assign on_sel[g] = (state_d == ON) && (idx_d == 2'(g));
    display_scan_lane #(.CAN_SUP(g != 0)) u_lane (
      .num_i    (snap_q.num[g]),
      .pt_i     (snap_q.pt[g]),
      .sup_hi_i (sup_chain[g+1]),
      .on_i     (on_sel[g]),
      .sup_o    (sup_chain[g]),
      .an_o     (an_d[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      an_q    <= '1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      tick_q  <= snap_take;
    end
  end

  assign num0       = snap_q.num[0];
  assign num1       = snap_q.num[1];
  assign num2       = snap_q.num[2];
  assign num3       = snap_q.num[3];
  assign point      = snap_q.pt;
  assign Sel1       = idx_q[1];
  assign Sel2       = idx_q[0];
  assign AN         = an_q;
  assign frame_tick = tick_q;

  a_one_cold: assert property (@(posedge clk) disable iff (reset)
    $countones(~AN) <= 1);
  a_dark_off_on: assert property (@(posedge clk) disable iff (reset)
    (state_q != ON) |-> (AN == 4'hF));
endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan: table of frames checked cycle by cycle, plus
// en-drop and mid-frame reset sequences.
module tb_display_scan;
  localparam int P = 8;
  localparam int B = 2;

  logic        clk = 1'b0;
  logic        reset, en, lz_en;
  logic [15:0] dl;
  logic [3:0]  dp_in;
  logic [3:0]  num0, num1, num2, num3, point, AN;
  logic        Sel1, Sel2, frame_tick;

  always #5 clk = ~clk;

  display_scan #(.PRESCALE(P), .BLANK_CYC(B)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .lz_en      (lz_en),
    .d0         (dl[3:0]),
    .d1         (dl[7:4]),
    .d2         (dl[11:8]),
    .d3         (dl[15:12]),
    .dp_in      (dp_in),
    .num0       (num0),
    .num1       (num1),
    .num2       (num2),
    .num3       (num3),
    .point      (point),
    .Sel1       (Sel1),
    .Sel2       (Sel2),
    .AN         (AN),
    .frame_tick (frame_tick)
  );

  // d = {d3,d2,d1,d0}; an = {AN in slot 3, slot 2, slot 1, slot 0}
  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  dp;
    logic        lz;
    logic [15:0] an;
  } vec_t;

  typedef struct packed {
    logic [3:0]  an;
    logic [1:0]  sel;
    logic [15:0] num;
    logic [3:0]  pt;
    logic        tick;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[10];
  exp_t rst_e, idle_e;
  int   nvec = 0;
  int   nfail = 0;

  function automatic exp_t frame_exp(input vec_t v, input int p);
    exp_t e;
    int s, o;
    s = p / P;
    o = p % P;
    e.an   = (o < B) ? 4'hF : v.an[s*4 +: 4];
    e.sel  = 2'(s);
    e.num  = v.d;
    e.pt   = v.dp;
    e.tick = (p == 0);
    return e;
  endfunction

  task automatic cyc(input exp_t e, input string nm, input int p);
    exp_t got, want;
    sb.push_back(e);
    @(posedge clk);
    #1;
    want     = sb.pop_front();
    got.an   = AN;
    got.sel  = {Sel1, Sel2};
    got.num  = {num3, num2, num1, num0};
    got.pt   = point;
    got.tick = frame_tick;
    nvec++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s p=%0d got an=%h sel=%0d num=%h pt=%b tick=%b, exp an=%h sel=%0d num=%h pt=%b tick=%b",
               nm, p, got.an, got.sel, got.num, got.pt, got.tick,
               want.an, want.sel, want.num, want.pt, want.tick);
    end
  endtask

  // Drives a frame's inputs, then scrambles the live inputs mid-frame to
  // show the latched values and suppression do not follow them.
  task automatic run_frame(input vec_t v, input int n, input string nm);
    dl    = v.d;
    dp_in = v.dp;
    lz_en = v.lz;
    en    = 1'b1;
    for (int p = 0; p < n; p++) begin
      if (p == 12) begin
        dl    = 16'($urandom);
        dp_in = 4'($urandom);
        lz_en = ~v.lz;
      end
      cyc(frame_exp(v, p), nm, p);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; lz_en = 1'b0; dl = '0; dp_in = '0;
    rst_e = '0;
    rst_e.an = 4'hF;

    tbl[0] = '{d:16'h1234, dp:4'b0010, lz:1'b0, an:16'h7BDE};
    tbl[1] = '{d:16'h1239, dp:4'b0010, lz:1'b0, an:16'h7BDE};
    tbl[2] = '{d:16'h0007, dp:4'b0000, lz:1'b1, an:16'hFFFE};
    tbl[3] = '{d:16'h0000, dp:4'b0100, lz:1'b1, an:16'hFBDE};
    tbl[4] = '{d:16'h0050, dp:4'b0000, lz:1'b1, an:16'hFFDE};
    tbl[5] = '{d:16'h0000, dp:4'b0000, lz:1'b1, an:16'hFFFE};
    tbl[6] = '{d:16'h0000, dp:4'b1000, lz:1'b1, an:16'h7BDE};
    tbl[7] = '{d:16'h0300, dp:4'b0000, lz:1'b1, an:16'hFBDE};
    tbl[8] = '{d:16'h9000, dp:4'b0000, lz:1'b1, an:16'h7BDE};
    tbl[9] = '{d:16'h0000, dp:4'b0000, lz:1'b0, an:16'h7BDE};

    repeat (2) cyc(rst_e, "reset", 0);
    reset = 1'b0;
    cyc(rst_e, "idle_no_en", 0);

    // Back-to-back frames: tick period and wrap snapshot are checked too.
    for (int i = 0; i < 10; i++) run_frame(tbl[i], 4 * P, "table");

    // Drop en in the ON phase of slot 2.
    run_frame(tbl[0], 2 * P + B + 2, "pre_drop");
    en = 1'b0;
    idle_e      = rst_e;
    idle_e.num  = tbl[0].d;
    idle_e.pt   = tbl[0].dp;
    repeat (3) cyc(idle_e, "en_drop", 0);
    run_frame(tbl[3], 4 * P, "restart");

    // Reset mid-frame with en held high.
    run_frame(tbl[4], 13, "pre_reset");
    reset = 1'b1;
    repeat (2) cyc(rst_e, "mid_reset", 0);
    reset = 1'b0;
    run_frame(tbl[1], 4 * P, "post_reset");
    en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexed scan controller for the 4-digit seven-segment display. It sits directly upstream of the 4-to-1 digit/decimal-point multiplexer. It snapshots the four BCD digits and the point mask once per frame, then drives that multiplexer's `Sel1`/`Sel2` selects. It also drives the active-low anode enables, with an inter-digit blanking gap against ghosting and optional leading-zero suppression.

## Interface
Parameters:
- `PRESCALE`, 50000: clock cycles per digit slot (1 kHz digit rate at 50 MHz); must be ≥ 4.
- `BLANK_CYC`, 500: cycles at the start of each slot with all anodes off; 1 ≤ BLANK_CYC < PRESCALE.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `en` in 1: scan enable; low means the display is dark and the scan is held.
- `lz_en` in 1: leading-zero suppression enable.
- `d0`,`d1`,`d2`,`d3` in 4 each: live digit values; `d3` is the most significant.
- `dp_in` in 4: live decimal-point mask; bit i belongs to digit i.
- `num0`,`num1`,`num2`,`num3` out 4 each: frame-latched digits, fed to the multiplexer.
- `point` out 4: frame-latched point mask, fed to the multiplexer.
- `Sel1`,`Sel2` out 1 each: digit select; {Sel1,Sel2} equals the current digit index.
- `AN` out 4: anode enables, active-low; bit i lights digit i.
- `frame_tick` out 1: one-cycle pulse when a new snapshot is taken.

## Operation
- State machine has three states: IDLE, BLANK and ON.
  - IDLE: `AN`=1111, digit index 0, prescaler 0. Leave when `en`=1, going to BLANK with digit 0 and taking a snapshot.
  - BLANK: `AN`=1111 for BLANK_CYC cycles, then go to ON.
  - ON: `AN` has bit idx low, unless that digit is suppressed. Stay for PRESCALE−BLANK_CYC cycles. Then increment idx (mod 4) and go to BLANK.
- The select changes only when entering BLANK. The anodes are therefore always dark when the multiplexer output changes.
- Snapshot: on every entry to BLANK with idx=0, register `d0..d3`→`num0..num3` and `dp_in`→`point`, and assert `frame_tick` for one cycle. Outputs hold for the whole frame, even if the live inputs change.
- Leading-zero suppression, evaluated on the snapshot values when `lz_en`=1:
  - Digit 3 is suppressed if num3==0 and point[3]==0.
  - Digit 2 is suppressed if digit 3 is suppressed, num2==0 and point[2]==0.
  - Digit 1 is suppressed if digit 2 is suppressed, num1==0 and point[1]==0.
  - Digit 0 is never suppressed.
  - A suppressed digit keeps `AN`=1111 through its ON phase; slot timing is unchanged.
- `lz_en` is sampled with the snapshot, so suppression is constant across a frame.
- `en` falling in any state: the next state is IDLE, with prescaler and idx cleared. The latched `num*`/`point` values are held.

## Timing
- Reset values:
  - `AN`=1111, `Sel1`=`Sel2`=0, `num0..3`=0, `point`=0000, `frame_tick`=0.
  - State IDLE, prescaler 0, idx 0.
- All outputs are registered. Combinational logic downstream sees only flop outputs.
- Latency from `en` rising (sampled at edge k) to snapshot, frame_tick and BLANK is edge k+1. The first anode goes low at edge k+1+BLANK_CYC.
- Slot length is exactly PRESCALE cycles. Frame length is exactly 4·PRESCALE cycles. `frame_tick` period is 4·PRESCALE.
- Index wraps from 3 to 0 and takes a snapshot on the same edge.
- `reset` dominates `en`. Reset mid-slot returns to the reset values on the next edge.
- If `en` and `reset` are both high, the block stays in IDLE.

## Test plan
Run with PRESCALE=8, BLANK_CYC=2.
- Reset then `en`=1 with d3..d0=1,2,3,4 and dp_in=0010. Required response:
  - `frame_tick` fires one cycle after `en`.
  - Per slot, {Sel1,Sel2} goes 00,01,10,11.
  - `AN` is 1111 for 2 cycles, then 1110/1101/1011/0111 for 6 cycles each.
  - `num*` equal 4,3,2,1 respectively; `point`=0010.
- Change `d0`→9 mid-frame. Required response: `num0` stays 4 until the next `frame_tick` (32 cycles after the previous one), then becomes 9.
- `lz_en`=1 with d3..d0=0,0,0,7. Required response: `AN` goes low only in slot 0. With d3..d0=0,0,0,0 and dp_in=0100, digits 2, 1 and 0 light and digit 3 stays dark.
- Drop `en` during an ON phase of slot 2. Required response:
  - `AN`=1111 and Sel=00 on the next edge.
  - Re-raising `en` gives `frame_tick` one edge later and a restart at digit 0.
- Assert `reset` mid-frame with `en`=1. Required response: every output is at its reset value on the next edge. Releasing `reset` restarts the scan at slot 0 with a new snapshot.
